// File: rtl/ram_port_arb_if.sv
// ---------------------------------------------------------------------------
// ram_port_arb_if
// Requester-side bus of the RAM port-B arbiter. It carries three requesters
// packed side by side. Requester i uses addr[i*AW +: AW] and wdata[i*DW +: DW].
//   req    : access request per requester, held until granted
//   we     : per-requester write enable, qualified by req
//   lock   : keep ownership of the port after the current grant
//   addr   : flat per-requester address
//   wdata  : flat per-requester write data
//   gnt    : one-hot, the access is accepted this cycle
//   rvalid : one-hot, rdata belongs to that requester this cycle
//   rdata  : read data shared by all requesters
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface ram_port_arb_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic [2:0]      req;
  logic [2:0]      we;
  logic [2:0]      lock;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt;
  logic [2:0]      rvalid;
  logic [DW-1:0]   rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_port_arb.sv
// ---------------------------------------------------------------------------
// ram_port_arb
// Shares port B of the 16K x 8 dual-port block RAM among three requesters
// (CPU second bus, DMA, video fetch). One access is granted per cycle. The
// grant and RAM command are combinational in the request cycle. Read data
// returns one cycle later with a one-hot rvalid for the requester that
// issued the read. A requester that is granted with lock set keeps the port
// for as long as it keeps requesting.
// Ports:
//   clk      : single clock for arbiter and RAM port B
//   reset    : asynchronous, active-high
//   bus      : requester bus (slave modport), see ram_port_arb_if
//   ram_ce   : RAM port-B clock enable (ceb)
//   ram_oce  : RAM port-B output clock enable (oceb), tied high
//   ram_we   : RAM port-B write enable (wreb)
//   ram_ad   : RAM port-B address (adb)
//   ram_din  : RAM port-B write data (dinb)
//   ram_dout : RAM port-B read data (doutb)
// Parameters: AW address width, DW data width, RR 1 = round-robin,
//             0 = fixed priority with requester 0 highest.
// ---------------------------------------------------------------------------
module ram_port_arb #(
  parameter int AW = 14,
  parameter int DW = 8,
  parameter int RR = 1
) (
  input  logic                clk,
  input  logic                reset,
  ram_port_arb_if.slave       bus,
  output logic                ram_ce,
  output logic                ram_oce,
  output logic                ram_we,
  output logic [AW-1:0]       ram_ad,
  output logic [DW-1:0]       ram_din,
  input  logic [DW-1:0]       ram_dout
);

  // Ownership doubles as the FSM state: OWN_NONE is IDLE, any other value is
  // LOCKED to that requester.
  typedef enum logic [1:0] {
    OWN_R0   = 2'd0,
    OWN_R1   = 2'd1,
    OWN_R2   = 2'd2,
    OWN_NONE = 2'd3
  } own_e;

  own_e       r_own,   w_own_nxt;
  logic [1:0] r_ptr,   w_ptr_nxt;
  logic [1:0] r_rsel,  w_rsel_nxt;
  logic       r_rpend, w_rpend_nxt;

  logic       w_found;
  logic [1:0] w_win;
  logic [1:0] w_own_idx;

  assign w_own_idx = r_own;

  // Winner selection. A locked owner that still requests wins outright;
  // otherwise scan three positions starting at the pointer (or at 0 for
  // fixed priority), wrapping modulo 3.
  always_comb begin : arbitrate
    logic [1:0] idx;
    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    w_found = 1'b0;
    w_win   = 2'd0;
    idx     = (RR != 0 && r_ptr != 2'd3) ? r_ptr : 2'd0;
    if (r_own != OWN_NONE && bus.req[w_own_idx]) begin
      w_found = 1'b1;
      w_win   = w_own_idx;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!w_found && bus.req[idx]) begin
          w_found = 1'b1;
          w_win   = idx;
        end
        idx = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
      end
    end
  end

  // Next-state and RAM command. Outputs are forced quiet while reset is
  // high because the grant path is purely combinational from req.
  always_comb begin : next_state
    w_ptr_nxt   = r_ptr;
    w_own_nxt   = OWN_NONE;   // no grant or lock released -> back to IDLE
    w_rpend_nxt = 1'b0;
    w_rsel_nxt  = r_rsel;
    bus.gnt     = 3'b000;
    ram_ce      = 1'b0;
    ram_we      = 1'b0;
    ram_ad      = '0;
    ram_din     = '0;
    if (w_found && !reset) begin
      bus.gnt   = 3'b001 << w_win;
      ram_ce    = 1'b1;
      ram_we    = bus.we[w_win];
      ram_ad    = bus.addr[w_win*AW +: AW];
      ram_din   = bus.wdata[w_win*DW +: DW];
      w_ptr_nxt = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
      if (bus.lock[w_win]) begin
        w_own_nxt = own_e'(w_win);
      end
      if (!bus.we[w_win]) begin
        w_rpend_nxt = 1'b1;
        w_rsel_nxt  = w_win;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above; the RAM array itself lives outside this
  // block and is never reset, only the arbiter's control state is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= 2'd0;
      r_own   <= OWN_NONE;
      r_rsel  <= 2'd0;
      r_rpend <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_own   <= w_own_nxt;
      r_rsel  <= w_rsel_nxt;
      r_rpend <= w_rpend_nxt;
    end
  end

  // Read return: the RAM output register already holds the data one cycle
  // after the read grant, so only the valid strobe needs steering.
  assign bus.rvalid = (r_rpend && !reset) ? (3'b001 << r_rsel) : 3'b000;
  assign bus.rdata  = ram_dout;
  assign ram_oce    = 1'b1;

endmodule

// File: doc/ram_port_arb.md
Name: ram_port_arb

Overview:
- Round-robin arbiter that shares one port of the 16K x 8 dual-port block RAM among three requesters: CPU second bus, DMA engine and video fetch.
- The block sits between the requesters and RAM port B. Port A stays dedicated to the CPU.
- It issues one RAM access per cycle and returns read data one cycle later with a per-requester valid pulse.
- A lock input lets the current owner hold the port for bursts.

Parameters:
- AW, 14, RAM address width.
- DW, 8, RAM data width.
- RR, 1, 1 = round-robin; 0 = fixed priority (req[0] highest).

Ports:
- clk  in  1  single clock, drives both the arbiter and RAM port B.
- reset  in  1  asynchronous, active-high.
- req  in  3  access request per requester; held until granted.
- we  in  3  per-requester write enable, qualified by req.
- lock  in  3  keep ownership after the current grant.
- addr  in  3*AW  flat per-requester address; requester i uses bits [i*AW +: AW].
- wdata  in  3*DW  flat per-requester write data.
- gnt  out  3  one-hot; the access is accepted in this cycle.
- rvalid  out  3  one-hot; read data valid for that requester.
- rdata  out  DW  read data, shared by all requesters.
- ram_ce  out  1  to ceb.
- ram_oce  out  1  to oceb, tied to 1.
- ram_we  out  1  to wreb.
- ram_ad  out  AW  to adb.
- ram_din  out  DW  to dinb.
- ram_dout  in  DW  from doutb.

Behaviour:
- Registered state:
  - ptr, 2 bits: round-robin start index, values 0..2.
  - own, 2 bits: locked owner; value 3 means no owner.
  - rsel, 2 bits: requester index of the read in flight.
  - rpend, 1 bit: a read is in flight.
- Reset values: ptr=0, own=3, rpend=0, rsel=0.
- While reset is high: gnt=0, rvalid=0, ram_ce=0, ram_we=0, ram_ad=0, ram_din=0, rdata=ram_dout.
- State machine:
  - IDLE (own=3): winner is the first requester with req set, scanning ptr, ptr+1, ptr+2 mod 3. With RR=0 the scan always starts at 0.
  - LOCKED (own=k): if req[k] is set, k wins unconditionally and other requests stall. If req[k] is clear, return to IDLE arbitration in the same cycle.
  - IDLE->LOCKED at the clock edge after a grant to k with lock[k]=1.
  - LOCKED->IDLE at the edge of any cycle where k is granted with lock[k]=0, or where req[k]=0.
- Grant path is combinational in cycle 0:
  - gnt[w]=1, ram_ce=1, ram_we=we[w], ram_ad=addr[w], ram_din=wdata[w].
  - The RAM samples at the end of cycle 0.
- Pointer update: ptr <= (w+1) mod 3 on every grant. ptr is unchanged in cycles with no grant.
- Read latency is 1:
  - For a granted read (we[w]=0): rpend<=1, rsel<=w.
  - In cycle 1, rvalid[rsel]=rpend and rdata=ram_dout.
  - Writes produce no rvalid.
- Back-to-back accesses: a new grant is allowed every cycle. A read in cycle n is returned in cycle n+1 while the access granted in cycle n+1 proceeds.
- RAM write-through: a write followed by a read of the same address in the next cycle returns the new data.
- No grant when req=0: ram_ce=0 and the address/data buses hold 0.
- Simultaneous requests: exactly one gnt bit is ever set. An illegal own value (3 is the only legal non-owner code) is treated as IDLE.
- Reset mid-burst: lock ownership and any in-flight rvalid are discarded. The first cycle after reset releases arbitrates from ptr=0.
- Port A collisions are not arbitrated here. The RAM forwards cross-port same-address writes by itself.

Test Plan:
- Single read: after reset, write 0x5A to 0x0123 via requester 1; next cycle read 0x0123 via requester 1 -> gnt=010 in both cycles; rvalid=010 with rdata=0x5A exactly one cycle after the read grant.
- Contention, RR=1: req=111 held continuously, no lock -> grants 001, 010, 100, 001, ... One grant per cycle, never two bits set.
- Fixed priority, RR=0: req=110 then 111 -> gnt 010 while req[0]=0; gnt 001 every cycle once req[0]=1.
- Lock burst: requester 2 holds req and lock for 4 reads of 0x0000..0x0003 while req[0] and req[1] are held -> 4 consecutive grants 100. The cycle after lock[2] drops, gnt goes to the next requester after 2 in round-robin order (001).
- Pipelined mixed traffic: requester 0 reads 0x3FFF, then requester 1 reads 0x0000 the next cycle -> rvalid=001 then 010, with the correct data in each cycle.
- Asynchronous reset during a lock and an in-flight read -> gnt, rvalid and ram_ce drop immediately. After release, ptr=0 and req=111 gives gnt=001.
